// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide engine driving the hi/lo register write port.
// One step per cycle in CALC; FINISH applies sign correction and pulses hilo_wr_en.
module hilo_muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_cpu,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [DATA_WIDTH-1:0]   rs_data,
    input  logic [DATA_WIDTH-1:0]   rt_data,
    input  logic                    flush,
    output logic                    busy,
    output logic                    hilo_wr_en,
    output logic [2*DATA_WIDTH-1:0] hilo_wr_data
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   counter_q, counter_d;
    logic            is_div_q, is_div_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dvz_q, dvz_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    rs_raw_q, rs_raw_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic            busy_q, busy_d;
    logic            wr_en_q, wr_en_d;
    logic [2*W-1:0]  wr_data_q, wr_data_d;

    logic            sgn_op;
    logic            a_neg, b_neg;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum;
    logic [W:0]      rem_sh;
    logic            div_ge;
    logic [W-1:0]    div_diff;
    logic [W-1:0]    quo_fix, rem_fix;
    logic [2*W-1:0]  prod_fix;

    always_comb begin
        sgn_op = ~op[0];
        a_neg  = sgn_op & rs_data[W-1];
        b_neg  = sgn_op & rt_data[W-1];
        mag_a  = a_neg ? (~rs_data + 1'b1) : rs_data;
        mag_b  = b_neg ? (~rt_data + 1'b1) : rt_data;
    end

    // Multiply: accumulator hi half collects partial sums, lo half holds the
    // shifting multiplier. Divide: accumulator is {remainder, quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = acc_q[2*W-1:W-1];
        div_ge   = (rem_sh >= {1'b0, opnd_q});
        div_diff = rem_sh[W-1:0] - opnd_q;
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_res_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dvz_d     = dvz_q;
        opnd_d    = opnd_q;
        rs_raw_d  = rs_raw_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dvz_d     = op[1] & (rt_data == '0);
                    rs_raw_d  = rs_data;
                    opnd_d    = op[1] ? mag_b : mag_a;
                    acc_d     = {{W{1'b0}}, (op[1] ? mag_a : mag_b)};
                    counter_d = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_d = div_ge ? {div_diff, acc_q[W-2:0], 1'b1}
                                   : {acc_q[2*W-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                counter_d = counter_q + 1'b1;
                if (counter_q == CW'(W - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                wr_en_d = 1'b1;
                if (!is_div_q) begin
                    wr_data_d = prod_fix;
                end else if (dvz_q) begin
                    wr_data_d = {rs_raw_q, {W{1'b1}}};
                end else begin
                    wr_data_d = {rem_fix, quo_fix};
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush overrides everything: abort, suppress any pending write.
        if (flush) begin
            state_d   = IDLE;
            wr_en_d   = 1'b0;
            wr_data_d = wr_data_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvz_q     <= 1'b0;
            opnd_q    <= '0;
            rs_raw_q  <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dvz_q     <= dvz_d;
            opnd_q    <= opnd_d;
            rs_raw_q  <= rs_raw_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy         = busy_q;
    assign hilo_wr_en   = wr_en_q;
    assign hilo_wr_data = wr_data_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: driver pushes expected {hi,lo} and due
// cycle, a negedge monitor pops and compares on every hilo_wr_en pulse.
module tb_hilo_muldiv_unit;

    logic        clk_cpu;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        busy;
    logic        hilo_wr_en;
    logic [63:0] hilo_wr_data;

    int unsigned errors;
    int unsigned checks;
    int unsigned edge_cnt;

    logic [63:0] exp_q[$];
    int unsigned due_q[$];

    hilo_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk_cpu      (clk_cpu),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .flush        (flush),
        .busy         (busy),
        .hilo_wr_en   (hilo_wr_en),
        .hilo_wr_data (hilo_wr_data)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    initial edge_cnt = 0;
    always @(posedge clk_cpu) edge_cnt <= edge_cnt + 1;

    // Reference model: plain 64-bit arithmetic with truncating division.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            2'b00: begin
                p = sa * sb;
                return p;
            end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding request.
    always @(negedge clk_cpu) begin
        if (hilo_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h at edge %0d, expected no write", hilo_wr_data, edge_cnt);
            end else begin
                logic [63:0] e;
                int unsigned d;
                e = exp_q.pop_front();
                d = due_q.pop_front();
                if (hilo_wr_data !== e || edge_cnt != d) begin
                    errors++;
                    $display("FAIL write: got %h at edge %0d, expected %h at edge %0d", hilo_wr_data, edge_cnt, e, d);
                end
            end
        end
    end

    // Called at a negedge; returns #1 after the sampling edge E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
        op = o;
        rs_data = a;
        rt_data = b;
        start = 1'b1;
        @(posedge clk_cpu);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
        if (expect_it) begin
            exp_q.push_back(model(o, a, b));
            due_q.push_back(edge_cnt + 33);
        end
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        @(negedge clk_cpu);
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk_cpu);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after 60 cycles, expected 0", busy);
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b, 1'b1);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned bcnt;
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        rs_data = '0;
        rt_data = '0;
        #12;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_wr_en", {63'h0, hilo_wr_en}, 64'h0);
        check("reset_wr_data", hilo_wr_data, 64'h0);
        @(negedge clk_cpu);
        reset_n = 1'b1;
        @(negedge clk_cpu);

        // Reset mid-CALC: outputs clear at once and no write follows.
        issue(2'b01, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        repeat (10) @(negedge clk_cpu);
        reset_n = 1'b0;
        #1;
        check("midreset_busy", {63'h0, busy}, 64'h0);
        check("midreset_wr_en", {63'h0, hilo_wr_en}, 64'h0);
        repeat (40) @(negedge clk_cpu);
        reset_n = 1'b1;
        @(negedge clk_cpu);

        // MULT -3*5 with busy-duration count.
        issue(2'b00, 32'hFFFFFFFD, 32'h5, 1'b1);
        bcnt = 0;
        @(negedge clk_cpu);
        while (busy === 1'b1 && bcnt < 60) begin
            bcnt++;
            @(negedge clk_cpu);
        end
        check("busy_cycles", 64'(bcnt), 64'd33);
        check("mult_neg_value", model(2'b00, 32'hFFFFFFFD, 32'h5), 64'hFFFFFFFF_FFFFFFF1);

        run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run(2'b11, 32'd100, 32'd7);
        run(2'b10, 32'hFFFFFFF9, 32'd2);
        run(2'b10, 32'h80000000, 32'hFFFFFFFF);
        run(2'b11, 32'd1234, 32'd0);
        run(2'b10, 32'hFFFFFF00, 32'd0);

        // Second start while busy is ignored.
        issue(2'b01, 32'd6, 32'd7, 1'b1);
        repeat (5) @(negedge clk_cpu);
        start = 1'b1;
        op = 2'b11;
        rs_data = 32'd99;
        rt_data = 32'd3;
        @(negedge clk_cpu);
        start = 1'b0;
        wait_idle();

        // Flush mid-CALC.
        issue(2'b00, 32'd11, 32'd13, 1'b0);
        repeat (19) @(negedge clk_cpu);
        flush = 1'b1;
        @(negedge clk_cpu);
        flush = 1'b0;
        check("flush_calc_busy", {63'h0, busy}, 64'h0);

        // Flush in the FINISH cycle suppresses the write.
        @(negedge clk_cpu);
        issue(2'b11, 32'd500, 32'd9, 1'b0);
        repeat (33) @(negedge clk_cpu);
        check("finish_cycle_busy", {63'h0, busy}, 64'h1);
        flush = 1'b1;
        @(negedge clk_cpu);
        flush = 1'b0;
        check("flush_finish_busy", {63'h0, busy}, 64'h0);
        check("flush_finish_wr_en", {63'h0, hilo_wr_en}, 64'h0);

        // flush + start together in IDLE: nothing starts.
        @(negedge clk_cpu);
        flush = 1'b1;
        start = 1'b1;
        op = 2'b01;
        @(negedge clk_cpu);
        flush = 1'b0;
        start = 1'b0;
        check("flush_start_busy", {63'h0, busy}, 64'h0);
        repeat (40) @(negedge clk_cpu);

        // Randomized back-to-back traffic with corner operands mixed in.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: ra = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run(ro, ra, rb);
        end

        repeat (5) @(negedge clk_cpu);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
